// File: rtl/axis_heartbeat_arbiter.sv
// axis_heartbeat_arbiter
// Packet-level arbiter for the heartbeat/SFP AXI-Stream multiplexer. It grants
// one of four sources and holds the grant until the muxed stream completes its
// last beat, so frames never interleave. It also counts completed packets per
// source. Source index order is heartbeat1=0, heartbeat2=1, heartbeat3=2, SFP=3.
module axis_heartbeat_arbiter #(
    parameter int ARB_MODE  = 0,   // 0: round-robin, 1: fixed priority hb1 > hb2 > hb3 > SFP
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_heartbeat1,
    input  logic                 req_heartbeat2,
    input  logic                 req_heartbeat3,
    input  logic                 req_SFP,
    input  logic                 mux_tvalid,
    input  logic                 mux_tready,
    input  logic                 mux_tlast,
    output logic                 grant_heartbeat1,
    output logic                 grant_heartbeat2,
    output logic                 grant_heartbeat3,
    output logic                 grant_SFP,
    output logic                 arb_busy,
    output logic [CNT_WIDTH-1:0] pkt_count_heartbeat1,
    output logic [CNT_WIDTH-1:0] pkt_count_heartbeat2,
    output logic [CNT_WIDTH-1:0] pkt_count_heartbeat3,
    output logic [CNT_WIDTH-1:0] pkt_count_SFP
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           grant_q, grant_d;
    logic [1:0]           ptr_q, ptr_d;      // last-granted source (round-robin only)
    logic [3:0]           req;
    logic [3:0]           winner;
    logic                 last_beat;
    logic [CNT_WIDTH-1:0] cnt_q [4];

    // Choose one requester. Round-robin searches starting just after the
    // pointer, so the source granted last is considered last.
    function automatic logic [3:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [3:0] g;
        logic [1:0] idx;
        g = '0;
        if (ARB_MODE != 0) begin
            for (int i = 0; i < 4; i++) begin
                if (r[i] && (g == 4'b0000)) g[i] = 1'b1;
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                idx = p + k[1:0];
                if (r[idx] && (g == 4'b0000)) g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

    // Index of a one-hot grant vector.
    function automatic logic [1:0] enc(input logic [3:0] g);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    assign req       = {req_SFP, req_heartbeat3, req_heartbeat2, req_heartbeat1};
    assign last_beat = mux_tvalid & mux_tready & mux_tlast;
    assign winner    = pick(req, ptr_q);

    // State, grant and pointer registers; pointer resets to SFP so heartbeat1 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic: arbitrate from IDLE, or re-arbitrate on the last beat
    // of the current packet so back-to-back packets have no bubble.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = BUSY;
                    grant_d = winner;
                    ptr_d   = enc(winner);
                end
            end
            BUSY: begin
                if (last_beat) begin
                    if (|req) begin
                        grant_d = winner;
                        ptr_d   = enc(winner);
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    // Per-source completed-packet counters, wrapping at 2^CNT_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else if ((state_q == BUSY) && last_beat) begin
            for (int i = 0; i < 4; i++) begin
                if (grant_q[i]) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    assign grant_heartbeat1     = grant_q[0];
    assign grant_heartbeat2     = grant_q[1];
    assign grant_heartbeat3     = grant_q[2];
    assign grant_SFP            = grant_q[3];
    assign arb_busy             = |grant_q;
    assign pkt_count_heartbeat1 = cnt_q[0];
    assign pkt_count_heartbeat2 = cnt_q[1];
    assign pkt_count_heartbeat3 = cnt_q[2];
    assign pkt_count_SFP        = cnt_q[3];

endmodule

// File: tb/tb_axis_heartbeat_arbiter.sv
// Scoreboard bench for axis_heartbeat_arbiter: a round-robin instance (16-bit
// counters) and a fixed-priority instance (2-bit counters) share the stimulus.
// Grant vectors are written {SFP, hb3, hb2, hb1}.
module tb_axis_heartbeat_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_heartbeat1 = 1'b0, req_heartbeat2 = 1'b0, req_heartbeat3 = 1'b0, req_SFP = 1'b0;
    logic mux_tvalid = 1'b0, mux_tready = 1'b0, mux_tlast = 1'b0;

    logic g0_hb1, g0_hb2, g0_hb3, g0_sfp, busy0;
    logic g1_hb1, g1_hb2, g1_hb3, g1_sfp, busy1;
    logic [15:0] c0_hb1, c0_hb2, c0_hb3, c0_sfp;
    logic [1:0]  c1_hb1, c1_hb2, c1_hb3, c1_sfp;

    axis_heartbeat_arbiter #(.ARB_MODE(0), .CNT_WIDTH(16)) dut_rr (
        .clk(clk), .rst(rst),
        .req_heartbeat1(req_heartbeat1), .req_heartbeat2(req_heartbeat2),
        .req_heartbeat3(req_heartbeat3), .req_SFP(req_SFP),
        .mux_tvalid(mux_tvalid), .mux_tready(mux_tready), .mux_tlast(mux_tlast),
        .grant_heartbeat1(g0_hb1), .grant_heartbeat2(g0_hb2),
        .grant_heartbeat3(g0_hb3), .grant_SFP(g0_sfp), .arb_busy(busy0),
        .pkt_count_heartbeat1(c0_hb1), .pkt_count_heartbeat2(c0_hb2),
        .pkt_count_heartbeat3(c0_hb3), .pkt_count_SFP(c0_sfp)
    );

    axis_heartbeat_arbiter #(.ARB_MODE(1), .CNT_WIDTH(2)) dut_fp (
        .clk(clk), .rst(rst),
        .req_heartbeat1(req_heartbeat1), .req_heartbeat2(req_heartbeat2),
        .req_heartbeat3(req_heartbeat3), .req_SFP(req_SFP),
        .mux_tvalid(mux_tvalid), .mux_tready(mux_tready), .mux_tlast(mux_tlast),
        .grant_heartbeat1(g1_hb1), .grant_heartbeat2(g1_hb2),
        .grant_heartbeat3(g1_hb3), .grant_SFP(g1_sfp), .arb_busy(busy1),
        .pkt_count_heartbeat1(c1_hb1), .pkt_count_heartbeat2(c1_hb2),
        .pkt_count_heartbeat3(c1_hb3), .pkt_count_SFP(c1_sfp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind 0: grant vector of instance d; kind 1: counter idx of instance d
    typedef struct {
        int    tag;
        int    d;
        int    kind;
        int    idx;
        int    val;
        string name;
    } item_t;

    item_t sb[$];
    int total = 0;
    int bad   = 0;

    function automatic int dut_grant(input int d);
        if (d == 0) return int'({g0_sfp, g0_hb3, g0_hb2, g0_hb1});
        return int'({g1_sfp, g1_hb3, g1_hb2, g1_hb1});
    endfunction

    function automatic int dut_busy(input int d);
        if (d == 0) return int'(busy0);
        return int'(busy1);
    endfunction

    function automatic int dut_cnt(input int d, input int idx);
        if (d == 0) begin
            case (idx)
                0: return int'(c0_hb1);
                1: return int'(c0_hb2);
                2: return int'(c0_hb3);
                default: return int'(c0_sfp);
            endcase
        end
        case (idx)
            0: return int'(c1_hb1);
            1: return int'(c1_hb2);
            2: return int'(c1_hb3);
            default: return int'(c1_sfp);
        endcase
    endfunction

    // Monitor: every falling edge, check invariants and retire due expectations.
    always @(negedge clk) begin
        int act;
        item_t it;
        for (int d = 0; d < 2; d++) begin
            act = dut_grant(d);
            total++;
            if (!$onehot0(act[3:0]) || (dut_busy(d) != int'(act != 0))) begin
                bad++;
                $display("FAIL onehot/busy dut%0d cyc %0d: grants=%b busy=%0d required one-hot and busy=|grants",
                         d, cyc, act[3:0], dut_busy(d));
            end
        end
        while ((sb.size() > 0) && (sb[0].tag <= cyc)) begin
            it = sb.pop_front();
            total++;
            if (it.tag < cyc) begin
                bad++;
                $display("FAIL %s: stale expectation for cyc %0d at cyc %0d", it.name, it.tag, cyc);
            end else begin
                act = (it.kind == 0) ? dut_grant(it.d) : dut_cnt(it.d, it.idx);
                if (act != it.val) begin
                    bad++;
                    $display("FAIL %s dut%0d cyc %0d: got %0d (0x%0h) expected %0d (0x%0h)",
                             it.name, it.d, cyc, act, act, it.val, it.val);
                end
            end
        end
    end

    // Drive one cycle of inputs and expect grant vector eg on instance d after the edge.
    task automatic step(input logic r, input logic [3:0] req, input logic v, input logic tr,
                        input logic tl, input logic [3:0] eg, input int d, input string name);
        item_t it;
        rst            = r;
        req_heartbeat1 = req[0];
        req_heartbeat2 = req[1];
        req_heartbeat3 = req[2];
        req_SFP        = req[3];
        mux_tvalid     = v;
        mux_tready     = tr;
        mux_tlast      = tl;
        it.tag = cyc + 1; it.d = d; it.kind = 0; it.idx = 0; it.val = int'(eg); it.name = name;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    // Expect counter idx of instance d to hold val in the current cycle.
    task automatic exp_cnt(input int d, input int idx, input int val, input string name);
        item_t it;
        it.tag = cyc; it.d = d; it.kind = 1; it.idx = idx; it.val = val; it.name = name;
        sb.push_back(it);
    endtask

    task automatic do_reset();
        step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 0, "reset_grant");
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] rr_seq [9];
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        @(posedge clk);
        #1;

        // Reset then idle
        for (int i = 0; i < 3; i++) step(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 0, "rst_grant");
        for (int i = 0; i < 20; i++) step(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 0, "idle_grant");
        for (int i = 0; i < 4; i++) exp_cnt(0, i, 0, "idle_cnt");
        for (int i = 0; i < 4; i++) exp_cnt(1, i, 0, "idle_cnt_fp");

        // Single SFP source: 4 beats, stalls, a tlast beat without tready
        step(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 4'b1000, 0, "sfp_grant");
        step(1'b0, 4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000, 0, "sfp_beat1");
        step(1'b0, 4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000, 0, "sfp_beat2");
        step(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 4'b1000, 0, "sfp_stall1");
        step(1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 4'b1000, 0, "sfp_stall2");
        step(1'b0, 4'b1000, 1'b1, 1'b1, 1'b0, 4'b1000, 0, "sfp_beat3");
        step(1'b0, 4'b1000, 1'b1, 1'b0, 1'b1, 4'b1000, 0, "sfp_last_noready");
        step(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 0, "sfp_done_idle");
        exp_cnt(0, 3, 1, "sfp_cnt");
        step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 0, "late_req_hb1");

        // Round-robin fairness, 2-beat packets, all requesting
        do_reset();
        step(1'b0, 4'b1111, 1'b0, 1'b0, 1'b0, rr_seq[0], 0, "rr_first");
        for (int p = 0; p < 8; p++) begin
            step(1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, rr_seq[p], 0, "rr_beat1");
            step(1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, rr_seq[p + 1], 0, "rr_next");
        end
        for (int i = 0; i < 4; i++) exp_cnt(0, i, 2, "rr_cnt");

        // Fixed priority, 1-beat packets; checked on the fixed-priority instance
        do_reset();
        step(1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 4'b0001, 1, "fp_first");
        for (int i = 0; i < 4; i++) step(1'b0, 4'b1001, 1'b1, 1'b1, 1'b1, 4'b0001, 1, "fp_hb1_again");
        step(1'b0, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b1000, 1, "fp_sfp_after_drop");
        step(1'b0, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b1000, 1, "fp_sfp_again");
        step(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 1, "fp_idle");
        exp_cnt(1, 0, 1, "fp_cnt_hb1_wrap");   // 5 packets mod 4
        exp_cnt(1, 3, 2, "fp_cnt_sfp");

        // Hold grant through a valid gap while another source requests
        do_reset();
        step(1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 4'b0010, 0, "hold_grant_hb2");
        step(1'b0, 4'b0110, 1'b1, 1'b1, 1'b0, 4'b0010, 0, "hold_beat1");
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0010, 0, "hold_gap");
        step(1'b0, 4'b0110, 1'b1, 1'b1, 1'b0, 4'b0010, 0, "hold_beat2");
        step(1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100, 0, "hold_then_hb3");
        step(1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b0000, 0, "hold_idle");
        exp_cnt(0, 1, 1, "hold_cnt_hb2");
        exp_cnt(0, 2, 1, "hold_cnt_hb3");

        // Reset in the middle of a heartbeat3 packet
        do_reset();
        step(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'b0100, 0, "mid_grant_hb3");
        step(1'b0, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100, 0, "mid_one_beat");
        exp_cnt(0, 2, 1, "mid_cnt_before");
        step(1'b0, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100, 0, "mid_beat1");
        step(1'b1, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0000, 0, "mid_rst_grant");
        exp_cnt(0, 2, 0, "mid_cnt_cleared");
        step(1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b0001, 0, "mid_after_rel");

        // Drain the scoreboard with a bounded wait
        for (int i = 0; (i < 5) && (sb.size() > 0); i++) @(posedge clk);
        @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
